// File: rtl/pipe_seq_pkg.sv
// Shared definitions for the pipeline sequencer: FSM state encoding and
// fixed stage indices.
package pipe_seq_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALT      = 2'd1,
    ST_STEP_WAIT = 2'd2
  } seq_state_t;

  localparam int IF_STAGE = 0;
  localparam int ID_STAGE = 1;

  // WB sits at the end of the pipe, so its index follows the stage count
  localparam int DEFAULT_STAGES = 5;
  localparam int WB_STAGE       = DEFAULT_STAGES - 1;

  function automatic int wb_stage(input int stages);
    return stages - 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/pipe_sequencer.sv
// In-order pipeline sequencer: stall, redirect, halt and statistics.
// Optional single-step mode is built when PIPE_SEQ_SINGLE_STEP_EN is defined.
module pipe_sequencer
  import pipe_seq_pkg::*;
#(
  parameter int STAGES         = 5,
  parameter int PC_W           = 12,
  parameter int RESET_PC       = 0,
  parameter int REDIRECT_STAGE = 2,
  parameter int CNT_W          = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hazard,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              halt_req,
  input  logic              resume,
  input  logic              step_mode,
  input  logic              step,
  output logic [PC_W-1:0]   pc,
  output logic [STAGES-1:0] valid,
  output logic [STAGES-1:0] adv,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic              halted,
  output logic              running
);

  localparam int WB = wb_stage(STAGES);

  if (STAGES < 4 || REDIRECT_STAGE < 2 || REDIRECT_STAGE > STAGES - 2) begin : g_bad_cfg
    $error("pipe_sequencer: need STAGES>=4 and 2<=REDIRECT_STAGE<=STAGES-2");
  end

  seq_state_t        state;
  seq_state_t        state_nxt;
  logic              go;
  logic              redir_acc;
  logic              bubble_acc;
  logic              halt_acc;
  logic [STAGES-1:0] valid_nxt;
  logic [PC_W-1:0]   pc_nxt;
  logic              unused_step;

  assign unused_step = ^{step_mode, step};

  always_comb begin
    go = (state == ST_RUN);
`ifdef PIPE_SEQ_SINGLE_STEP_EN
    if (state == ST_STEP_WAIT && step) go = 1'b1;
`endif
    redir_acc  = go && redirect && valid[REDIRECT_STAGE];
    bubble_acc = go && hazard && valid[ID_STAGE] && !redir_acc;
    halt_acc   = (state == ST_RUN) && halt_req && valid[WB];

    adv       = '0;
    valid_nxt = valid;
    pc_nxt    = pc;
    if (go) begin
      adv = '1;
      valid_nxt[IF_STAGE] = 1'b1;
      for (int i = 1; i < STAGES; i++) valid_nxt[i] = valid[i-1];
      pc_nxt = pc + PC_W'(4);
      if (redir_acc) begin
        pc_nxt = redirect_pc;
        for (int i = 1; i <= REDIRECT_STAGE; i++) valid_nxt[i] = 1'b0;
      end else if (bubble_acc) begin
        // IF/ID hold their contents; a bubble is injected into stage 2
        adv[ID_STAGE:IF_STAGE]  = '0;
        valid_nxt[IF_STAGE]     = valid[IF_STAGE];
        valid_nxt[ID_STAGE]     = valid[ID_STAGE];
        valid_nxt[ID_STAGE + 1] = 1'b0;
        pc_nxt                  = pc;
      end
    end

    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (halt_acc) state_nxt = ST_HALT;
`ifdef PIPE_SEQ_SINGLE_STEP_EN
        else if (step_mode) state_nxt = ST_STEP_WAIT;
`endif
      end
      ST_HALT: if (resume) state_nxt = ST_RUN;
      ST_STEP_WAIT: begin
`ifdef PIPE_SEQ_SINGLE_STEP_EN
        if (!step_mode) state_nxt = ST_RUN;
`else
        state_nxt = ST_RUN;
`endif
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_RUN;
      pc      <= PC_W'(RESET_PC);
      valid   <= STAGES'(1);
      halted  <= 1'b0;
      running <= 1'b1;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      valid   <= valid_nxt;
      halted  <= (state_nxt == ST_HALT);
      running <= (state_nxt == ST_RUN);
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (state != ST_HALT),
    .count (cycle_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_retire_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (adv[WB] && valid[WB]),
    .count (retire_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (bubble_acc),
    .count (bubble_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clear (rst),
    .inc   (redir_acc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed bench for pipe_sequencer: a default-width instance plus a
// CNT_W=4 instance on the same stimulus for counter saturation.
module tb_pipe_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hazard = 1'b0;
  logic        redirect = 1'b0;
  logic [11:0] redirect_pc = 12'h000;
  logic        halt_req = 1'b0;
  logic        resume = 1'b0;
  logic        step_mode = 1'b0;
  logic        step = 1'b0;

  logic [11:0] pc;
  logic [4:0]  valid, adv;
  logic [31:0] cycle_cnt, retire_cnt, bubble_cnt, flush_cnt;
  logic        halted, running;

  logic [11:0] pc4;
  logic [4:0]  valid4, adv4;
  logic [3:0]  cycle4, retire4, bubble4, flush4;
  logic        halted4, running4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_sequencer dut (
    .clk(clk), .rst(rst), .hazard(hazard), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt_req(halt_req), .resume(resume),
    .step_mode(step_mode), .step(step), .pc(pc), .valid(valid), .adv(adv),
    .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt),
    .flush_cnt(flush_cnt), .halted(halted), .running(running)
  );

  pipe_sequencer #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .hazard(hazard), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt_req(halt_req), .resume(resume),
    .step_mode(step_mode), .step(step), .pc(pc4), .valid(valid4), .adv(adv4),
    .cycle_cnt(cycle4), .retire_cnt(retire4), .bubble_cnt(bubble4),
    .flush_cnt(flush4), .halted(halted4), .running(running4)
  );

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++; if (pc !== 12'h000) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 12'h000); end
    checks++; if (valid !== 5'b00001) begin errors++; $display("FAIL reset_valid: got %b expected %b", valid, 5'b00001); end
    checks++; if ({cycle_cnt, retire_cnt, bubble_cnt, flush_cnt} !== 128'd0) begin errors++; $display("FAIL reset_counters: got %0d %0d %0d %0d expected all 0", cycle_cnt, retire_cnt, bubble_cnt, flush_cnt); end
    checks++; if ({running, halted} !== 2'b10) begin errors++; $display("FAIL reset_state: got running=%b halted=%b expected 1 0", running, halted); end
  endtask

  task automatic test_run();
    tick(10);
    checks++; if (pc !== 12'h028) begin errors++; $display("FAIL run_pc: got %h expected %h", pc, 12'h028); end
    checks++; if (valid !== 5'b11111) begin errors++; $display("FAIL run_valid: got %b expected %b", valid, 5'b11111); end
    checks++; if (cycle_cnt !== 32'd10) begin errors++; $display("FAIL run_cycle_cnt: got %0d expected 10", cycle_cnt); end
    checks++; if (retire_cnt !== 32'd6) begin errors++; $display("FAIL run_retire_cnt: got %0d expected 6", retire_cnt); end
    checks++; if (adv !== 5'b11111) begin errors++; $display("FAIL run_adv: got %b expected %b", adv, 5'b11111); end
  endtask

  task automatic test_bubble();
    hazard = 1'b1;
    #1;
    checks++; if (adv !== 5'b11100) begin errors++; $display("FAIL bubble_adv: got %b expected %b", adv, 5'b11100); end
    tick(1);
    hazard = 1'b0;
    checks++; if (pc !== 12'h028) begin errors++; $display("FAIL bubble_pc: got %h expected %h", pc, 12'h028); end
    checks++; if (valid !== 5'b11011) begin errors++; $display("FAIL bubble_valid: got %b expected %b", valid, 5'b11011); end
    checks++; if (bubble_cnt !== 32'd1) begin errors++; $display("FAIL bubble_cnt: got %0d expected 1", bubble_cnt); end
    checks++; if (retire_cnt !== 32'd7) begin errors++; $display("FAIL bubble_retire_cnt: got %0d expected 7", retire_cnt); end
  endtask

  task automatic test_redirect();
    tick(1);
    checks++; if (valid !== 5'b10111) begin errors++; $display("FAIL pre_redirect_valid: got %b expected %b", valid, 5'b10111); end
    redirect = 1'b1; hazard = 1'b1; redirect_pc = 12'h100;
    #1;
    checks++; if (adv !== 5'b11111) begin errors++; $display("FAIL redirect_adv: got %b expected %b", adv, 5'b11111); end
    tick(1);
    checks++; if (pc !== 12'h100) begin errors++; $display("FAIL redirect_pc: got %h expected %h", pc, 12'h100); end
    checks++; if (valid !== 5'b01001) begin errors++; $display("FAIL redirect_valid: got %b expected %b", valid, 5'b01001); end
    checks++; if (flush_cnt !== 32'd1) begin errors++; $display("FAIL redirect_flush_cnt: got %0d expected 1", flush_cnt); end
    checks++; if (bubble_cnt !== 32'd1) begin errors++; $display("FAIL redirect_bubble_cnt: got %0d expected 1", bubble_cnt); end
    // stage 2 and ID now empty: both requests must be ignored
    tick(1);
    redirect = 1'b0; hazard = 1'b0;
    checks++; if (pc !== 12'h104) begin errors++; $display("FAIL ignored_redirect_pc: got %h expected %h", pc, 12'h104); end
    checks++; if (valid !== 5'b10011) begin errors++; $display("FAIL ignored_redirect_valid: got %b expected %b", valid, 5'b10011); end
    checks++; if ({flush_cnt, bubble_cnt} !== {32'd1, 32'd1}) begin errors++; $display("FAIL ignored_redirect_cnt: got flush=%0d bubble=%0d expected 1 1", flush_cnt, bubble_cnt); end
    checks++; if ({cycle_cnt, retire_cnt} !== {32'd14, 32'd9}) begin errors++; $display("FAIL ignored_redirect_stats: got cycle=%0d retire=%0d expected 14 9", cycle_cnt, retire_cnt); end
  endtask

  task automatic test_halt();
    halt_req = 1'b1;
    tick(1);
    checks++; if ({running, halted} !== 2'b01) begin errors++; $display("FAIL halt_state: got running=%b halted=%b expected 0 1", running, halted); end
    checks++; if (valid !== 5'b00111) begin errors++; $display("FAIL halt_valid: got %b expected %b", valid, 5'b00111); end
    checks++; if (retire_cnt !== 32'd10) begin errors++; $display("FAIL halt_retire_cnt: got %0d expected 10", retire_cnt); end
    hazard = 1'b1; redirect = 1'b1;
    for (int k = 0; k < 20; k++) begin
      checks++; if (adv !== 5'b00000) begin errors++; $display("FAIL halt_adv: got %b expected %b at cycle %0d", adv, 5'b00000, k); end
      tick(1);
    end
    checks++; if (pc !== 12'h108) begin errors++; $display("FAIL halt_pc: got %h expected %h", pc, 12'h108); end
    checks++; if (valid !== 5'b00111) begin errors++; $display("FAIL halt_hold_valid: got %b expected %b", valid, 5'b00111); end
    checks++; if ({cycle_cnt, retire_cnt, bubble_cnt, flush_cnt} !== {32'd15, 32'd10, 32'd1, 32'd1}) begin errors++; $display("FAIL halt_counters: got %0d %0d %0d %0d expected 15 10 1 1", cycle_cnt, retire_cnt, bubble_cnt, flush_cnt); end
    halt_req = 1'b0; hazard = 1'b0; redirect = 1'b0; resume = 1'b1;
    #1;
    checks++; if (adv !== 5'b00000) begin errors++; $display("FAIL resume_adv: got %b expected %b", adv, 5'b00000); end
    tick(1);
    resume = 1'b0;
    checks++; if ({running, halted} !== 2'b10) begin errors++; $display("FAIL resume_state: got running=%b halted=%b expected 1 0", running, halted); end
    checks++; if ({pc, cycle_cnt} !== {12'h108, 32'd15}) begin errors++; $display("FAIL resume_pc_cycle: got pc=%h cycle=%0d expected 108 15", pc, cycle_cnt); end
    halt_req = 1'b1;
    tick(1);
    halt_req = 1'b0;
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL no_rehalt: got running=%b expected 1", running); end
    checks++; if ({pc, valid, cycle_cnt} !== {12'h10C, 5'b01111, 32'd16}) begin errors++; $display("FAIL after_resume: got pc=%h valid=%b cycle=%0d expected 10c 01111 16", pc, valid, cycle_cnt); end
  endtask

  task automatic test_saturation();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    hazard = 1'b1;
    tick(20);
    hazard = 1'b0;
    redirect = 1'b1; redirect_pc = 12'h100;
    tick(60);
    redirect = 1'b0;
    tick(30);
    checks++; if ({cycle4, retire4, bubble4, flush4} !== 16'hFFFF) begin errors++; $display("FAIL sat_cnt4: got %h %h %h %h expected f f f f", cycle4, retire4, bubble4, flush4); end
    checks++; if (cycle_cnt !== 32'd110) begin errors++; $display("FAIL sat_wide_cycle: got %0d expected 110", cycle_cnt); end
    checks++; if (bubble_cnt !== 32'd19) begin errors++; $display("FAIL sat_wide_bubble: got %0d expected 19", bubble_cnt); end
    checks++; if (flush_cnt !== 32'd20) begin errors++; $display("FAIL sat_wide_flush: got %0d expected 20", flush_cnt); end
  endtask

  task automatic test_step();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    step_mode = 1'b1;
`ifdef PIPE_SEQ_SINGLE_STEP_EN
    tick(1);
    checks++; if ({running, halted} !== 2'b00) begin errors++; $display("FAIL step_enter: got running=%b halted=%b expected 0 0", running, halted); end
    tick(3);
    checks++; if ({pc, cycle_cnt} !== {12'h004, 32'd4}) begin errors++; $display("FAIL step_wait_hold: got pc=%h cycle=%0d expected 004 4", pc, cycle_cnt); end
    checks++; if (adv !== 5'b00000) begin errors++; $display("FAIL step_wait_adv: got %b expected %b", adv, 5'b00000); end
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      tick(1);
      step = 1'b0;
      tick(1);
    end
    checks++; if (pc !== 12'h010) begin errors++; $display("FAIL step_pc: got %h expected %h", pc, 12'h010); end
    checks++; if ({valid, cycle_cnt} !== {5'b11111, 32'd10}) begin errors++; $display("FAIL step_valid_cycle: got valid=%b cycle=%0d expected 11111 10", valid, cycle_cnt); end
    step_mode = 1'b0;
    tick(1);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL step_exit: got running=%b expected 1", running); end
`else
    for (int k = 0; k < 3; k++) begin
      step = 1'b1;
      tick(1);
      step = 1'b0;
      tick(2);
    end
    step_mode = 1'b0;
    checks++; if ({running, pc} !== {1'b1, 12'h024}) begin errors++; $display("FAIL step_ignored: got running=%b pc=%h expected 1 024", running, pc); end
    checks++; if (cycle_cnt !== 32'd9) begin errors++; $display("FAIL step_ignored_cycle: got %0d expected 9", cycle_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_run();
    test_bubble();
    test_redirect();
    test_halt();
    test_saturation();
    test_step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
